// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions for the Booth multiplier / divider pair.
package arith_pkg;

   localparam int ARITH_W = 4;

   typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/signed_abs.sv
// Two's-complement magnitude and sign; the most-negative value maps to 2^(W-1) unsigned.
module signed_abs import arith_pkg::*; #(
   parameter int W = ARITH_W
) (
   input  logic [W-1:0] a,
   output logic [W-1:0] mag,
   output logic         sgn
);

   assign sgn = a[W-1];
   assign mag = a[W-1] ? (~a + W'(1)) : a;

endmodule

// File: rtl/booth_divider.sv
// Sequential signed restoring divider: one quotient bit per cycle on magnitudes,
// sign correction of quotient and remainder in the result register stage.
module booth_divider import arith_pkg::*; #(
   parameter int W = ARITH_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] X,
   input  logic [W-1:0] Y,
   output logic [W-1:0] Q,
   output logic [W-1:0] R,
   output logic         valid,
   output logic         busy,
   output logic         dz,
   output logic         ovf
);

   localparam int CW = cnt_width(W);
   localparam logic [W-1:0] XMIN = {1'b1, {(W-1){1'b0}}};

   div_state_t    state;
   logic [CW-1:0] cnt;
   logic [W:0]    rem;
   logic [W-1:0]  quo, ay, xr;
   logic          sx, sy, dzp, ovp;

   logic [W-1:0]  ax_w, ay_w;
   logic          sx_w, sy_w;
   logic [W:0]    rem_sh, trial;

   signed_abs #(.W(W)) u_abs_x (.a(X), .mag(ax_w), .sgn(sx_w));
   signed_abs #(.W(W)) u_abs_y (.a(Y), .mag(ay_w), .sgn(sy_w));

   // rem < |Y| <= 2^(W-1) keeps the shifted value below 2^W, so bit W is the trial sign
   assign rem_sh = {rem[W-1:0], quo[W-1]};
   assign trial  = rem_sh - {1'b0, ay};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         ay    <= '0;
         xr    <= '0;
         sx    <= 1'b0;
         sy    <= 1'b0;
         dzp   <= 1'b0;
         ovp   <= 1'b0;
         Q     <= '0;
         R     <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
         dz    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               ay    <= ay_w;
               quo   <= ax_w;
               rem   <= '0;
               sx    <= sx_w;
               sy    <= sy_w;
               xr    <= X;
               dzp   <= (Y == '0);
               ovp   <= (X == XMIN) && (Y == '1);
               // a zero divisor still spends one CALC cycle so its result lands at N+2
               cnt   <= (Y == '0) ? CW'(1) : CW'(W);
               valid <= 1'b0;
               dz    <= 1'b0;
               ovf   <= 1'b0;
               busy  <= 1'b1;
               state <= CALC;
            end
            CALC: begin
               rem <= trial[W] ? rem_sh : trial;
               quo <= {quo[W-2:0], ~trial[W]};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= DONE;
            end
            DONE: begin
               if (dzp) begin
                  Q <= '1;
                  R <= xr;
               end else begin
                  Q <= (sx ^ sy) ? (~quo + W'(1)) : quo;
                  R <= sx ? (~rem[W-1:0] + W'(1)) : rem[W-1:0];
               end
               dz    <= dzp;
               ovf   <= ovp;
               valid <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider at W=4: directed table, corner sequences,
// exhaustive back-to-back sweep and random ops against a truncating-division model.
module tb_booth_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] X = '0, Y = '0;
   logic [W-1:0] Q, R;
   logic         valid, busy, dz, ovf;

   int checks = 0;
   int failures = 0;

   booth_divider #(.W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y),
      .Q(Q), .R(R), .valid(valid), .busy(busy), .dz(dz), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x, y, q, r, d, o, lat;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Truncating signed division on plain integers, then wrapped to W bits.
   task automatic model(input int x, input int y, output int q, output int r,
                        output int d, output int o);
      int qi, ri;
      logic signed [W-1:0] qw, rw;
      d = 0;
      o = 0;
      if (y == 0) begin
         qi = -1;
         ri = x;
         d  = 1;
      end else begin
         qi = x / y;
         ri = x % y;
         o  = (qi > (2**(W-1)) - 1) ? 1 : 0;
      end
      qw = qi[W-1:0];
      rw = ri[W-1:0];
      q = int'(qw);
      r = int'(rw);
   endtask

   // Called #1 after an edge; waits for valid, checking busy on every pending cycle.
   task automatic wait_res(input int lat0, output int lat);
      lat = lat0;
      while (!valid && lat < 40) begin
         chk("busy_pending", int'(busy), 1);
         @(posedge clk); #1;
         lat++;
      end
      chk("busy_at_valid", int'(busy), 0);
   endtask

   task automatic do_op(input int x, input int y, output int q, output int r,
                        output int d, output int o, output int lat);
      X = x[W-1:0];
      Y = y[W-1:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_res(0, lat);
      q = int'($signed(Q));
      r = int'($signed(R));
      d = int'(dz);
      o = int'(ovf);
   endtask

   task automatic check_op(input string tag, input int x, input int y, input int gap);
      int q, r, d, o, lat, eq, er, ed, eo;
      repeat (gap) begin @(posedge clk); #1; end
      do_op(x, y, q, r, d, o, lat);
      model(x, y, eq, er, ed, eo);
      chk({tag, "_q"}, q, eq);
      chk({tag, "_r"}, r, er);
      chk({tag, "_dz"}, d, ed);
      chk({tag, "_ovf"}, o, eo);
      chk({tag, "_lat"}, lat, (y == 0) ? 2 : W + 1);
      if (y != 0 && eo == 0) chk({tag, "_ident"}, q * y + r, x);
   endtask

   initial begin
      int q, r, d, o, lat;

      tbl[0] = '{x:  7, y:  2, q:  3, r:  1, d: 0, o: 0, lat: 5};
      tbl[1] = '{x: -7, y:  2, q: -3, r: -1, d: 0, o: 0, lat: 5};
      tbl[2] = '{x:  6, y: -3, q: -2, r:  0, d: 0, o: 0, lat: 5};
      tbl[3] = '{x: -2, y: -2, q:  1, r:  0, d: 0, o: 0, lat: 5};
      tbl[4] = '{x: -8, y: -1, q: -8, r:  0, d: 0, o: 1, lat: 5};
      tbl[5] = '{x:  5, y:  0, q: -1, r:  5, d: 1, o: 0, lat: 2};

      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q", int'(Q), 0);
      chk("rst_r", int'(R), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_dz", int'(dz), 0);
      chk("rst_ovf", int'(ovf), 0);
      rst = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         do_op(tbl[i].x, tbl[i].y, q, r, d, o, lat);
         chk("tbl_q", q, tbl[i].q);
         chk("tbl_r", r, tbl[i].r);
         chk("tbl_dz", d, tbl[i].d);
         chk("tbl_ovf", o, tbl[i].o);
         chk("tbl_lat", lat, tbl[i].lat);
      end

      // start pulse during CALC must not disturb the running 7/3
      X = 4'd7; Y = 4'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("ign_busy1", int'(busy), 1);
      X = 4'd1; Y = 4'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_res(2, lat);
      chk("ign_q", int'($signed(Q)), 2);
      chk("ign_r", int'($signed(R)), 1);
      chk("ign_lat", lat, 5);
      @(posedge clk); #1;
      chk("ign_no_restart", int'(busy), 0);

      // reset in the middle of CALC aborts the operation
      X = 4'd7; Y = 4'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mrst_q", int'(Q), 0);
      chk("mrst_r", int'(R), 0);
      chk("mrst_valid", int'(valid), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_dz", int'(dz), 0);
      chk("mrst_ovf", int'(ovf), 0);
      rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("mrst_no_result", int'(valid), 0);
      do_op(3, 3, q, r, d, o, lat);
      chk("post_rst_q", q, 1);
      chk("post_rst_r", r, 0);
      chk("post_rst_lat", lat, 5);

      // exhaustive back-to-back sweep: each start issued the cycle after valid
      for (int x = -(2**(W-1)); x < 2**(W-1); x++)
         for (int y = -(2**(W-1)); y < 2**(W-1); y++)
            if (y != 0) check_op("sweep", x, y, 0);

      for (int n = 0; n < 120; n++) begin
         int rx, ry;
         rx = int'($urandom_range(2**W - 1)) - 2**(W-1);
         ry = int'($urandom_range(2**W - 1)) - 2**(W-1);
         check_op("rand", rx, ry, int'($urandom_range(2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
